// File: rtl/ofdm_pkg.sv
// Shared OFDM subcarrier definitions: carrier classes, the k->class rule and
// a per-symbol data-carrier count for upstream counters and benches.
package ofdm_pkg;

  typedef enum logic [1:0] {
    SC_NULL  = 2'd0,
    SC_PILOT = 2'd1,
    SC_DATA  = 2'd2
  } sc_class_t;

  // DC and the band around Nyquist are null; null wins over pilot
  function automatic sc_class_t sc_class(
    input int unsigned k,
    input int unsigned n_fft,
    input int unsigned guard_half,
    input int unsigned pilot_step,
    input int unsigned pilot_offset
  );
    if (k == 0 ||
        (k >= n_fft / 2 - guard_half && k <= n_fft / 2 + guard_half - 1))
      return SC_NULL;
    if ((k % pilot_step) == pilot_offset)
      return SC_PILOT;
    return SC_DATA;
  endfunction

  function automatic int unsigned n_data_per_sym(
    input int unsigned n_fft,
    input int unsigned guard_half,
    input int unsigned pilot_step,
    input int unsigned pilot_offset
  );
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < n_fft; k++) begin
      if (sc_class(k, n_fft, guard_half, pilot_step, pilot_offset) == SC_DATA)
        n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/ofdm_sc_classify.sv
// Combinational subcarrier index -> class lookup, shared with the receiver demapper.
module ofdm_sc_classify
  import ofdm_pkg::*;
#(
  parameter int unsigned N_FFT        = 64,
  parameter int unsigned GUARD_HALF   = 6,
  parameter int unsigned PILOT_STEP   = 8,
  parameter int unsigned PILOT_OFFSET = 4,
  localparam int unsigned KW          = $clog2(N_FFT)
) (
  input  logic [KW-1:0] k,
  output sc_class_t     sc_class_c
);

  assign sc_class_c = sc_class(32'(k), N_FFT, GUARD_HALF, PILOT_STEP, PILOT_OFFSET);

endmodule

// File: rtl/ofdm_sc_mapper.sv
// Builds one OFDM symbol in FFT input order from QAM data, pilot signs and
// internal nulls, with ready/valid on every side and SOP/EOP framing.
module ofdm_sc_mapper
  import ofdm_pkg::*;
#(
  parameter int unsigned N_FFT        = 64,
  parameter int unsigned DW           = 16,
  parameter int unsigned GUARD_HALF   = 6,
  parameter int unsigned PILOT_STEP   = 8,
  parameter int unsigned PILOT_OFFSET = 4,
  parameter int          PILOT_AMP    = 11585,
  parameter int unsigned SYM_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DW-1:0]    data_i,
  input  logic [DW-1:0]    data_q,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             pilot_sign,
  input  logic             pilot_valid,
  output logic             pilot_ready,
  input  logic             ready_in,
  output logic [DW-1:0]    real_out,
  output logic [DW-1:0]    imag_out,
  output logic             valid_out,
  output logic             sop_out,
  output logic             eop_out,
  output logic [SYM_W-1:0] sym_cnt
);

  localparam int unsigned KW        = $clog2(N_FFT);
  localparam logic [KW-1:0] K_LAST  = KW'(N_FFT - 1);
  localparam logic [DW-1:0] PILOT_P = DW'(PILOT_AMP);
  localparam logic [DW-1:0] PILOT_N = DW'(-PILOT_AMP);

  // Parameter sanity, caught at elaboration
  if (N_FFT < 8 || N_FFT > 1024 || (N_FFT & (N_FFT - 1)) != 0) begin : g_bad_nfft
    $error("ofdm_sc_mapper: N_FFT must be a power of 2 in 8..1024");
  end
  if (GUARD_HALF >= N_FFT / 2) begin : g_bad_guard
    $error("ofdm_sc_mapper: N_FFT/2 - GUARD_HALF must be > 0");
  end
  if (PILOT_STEP == 0 || (PILOT_STEP & (PILOT_STEP - 1)) != 0) begin : g_bad_step
    $error("ofdm_sc_mapper: PILOT_STEP must be a power of 2");
  end
  if (PILOT_OFFSET >= PILOT_STEP) begin : g_bad_offset
    $error("ofdm_sc_mapper: PILOT_OFFSET must be < PILOT_STEP");
  end
  if (PILOT_AMP < 0 || longint'(PILOT_AMP) > ((longint'(1) <<< (DW - 1)) - 1)) begin : g_bad_amp
    $error("ofdm_sc_mapper: PILOT_AMP must fit DW bits signed");
  end

  logic [KW-1:0] k;
  sc_class_t     cls_c;
  logic          can_load_c;
  logic          avail_c;
  logic          load_c;

  ofdm_sc_classify #(
    .N_FFT        (N_FFT),
    .GUARD_HALF   (GUARD_HALF),
    .PILOT_STEP   (PILOT_STEP),
    .PILOT_OFFSET (PILOT_OFFSET)
  ) u_classify (
    .k          (k),
    .sc_class_c (cls_c)
  );

  // Whether the source owning the current carrier has a sample ready
  always_comb begin
    avail_c = 1'b0;
    case (cls_c)
      SC_NULL:  avail_c = 1'b1;
      SC_PILOT: avail_c = pilot_valid;
      SC_DATA:  avail_c = data_valid;
      default:  avail_c = 1'b0;
    endcase
  end

  assign can_load_c  = en & (~valid_out | ready_in);
  assign load_c      = can_load_c & avail_c;
  assign data_ready  = can_load_c & (cls_c == SC_DATA);
  assign pilot_ready = can_load_c & (cls_c == SC_PILOT);

  // Single output stage; a missing source stalls on the same k
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      sym_cnt   <= '0;
      real_out  <= '0;
      imag_out  <= '0;
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end else if (load_c) begin
      valid_out <= 1'b1;
      sop_out   <= (k == '0);
      eop_out   <= (k == K_LAST);
      k         <= k + KW'(1);
      if (k == K_LAST)
        sym_cnt <= sym_cnt + SYM_W'(1);
      case (cls_c)
        SC_PILOT: begin
          real_out <= pilot_sign ? PILOT_N : PILOT_P;
          imag_out <= '0;
        end
        SC_DATA: begin
          real_out <= data_i;
          imag_out <= data_q;
        end
        default: begin
          real_out <= '0;
          imag_out <= '0;
        end
      endcase
    end else if (can_load_c) begin
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofdm_sc_mapper.sv
// Directed bench for ofdm_sc_mapper on a 16-carrier layout with a
// cycle-level reference model built from a hand-written carrier map.
module tb_ofdm_sc_mapper;
  import ofdm_pkg::*;

  localparam int unsigned N     = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned SYM_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DW-1:0]    data_i;
  logic [DW-1:0]    data_q;
  logic             data_valid;
  logic             data_ready;
  logic             pilot_sign;
  logic             pilot_valid;
  logic             pilot_ready;
  logic             ready_in;
  logic [DW-1:0]    real_out;
  logic [DW-1:0]    imag_out;
  logic             valid_out;
  logic             sop_out;
  logic             eop_out;
  logic [SYM_W-1:0] sym_cnt;

  ofdm_sc_mapper #(
    .N_FFT        (N),
    .DW           (DW),
    .GUARD_HALF   (2),
    .PILOT_STEP   (4),
    .PILOT_OFFSET (2),
    .PILOT_AMP    (11585),
    .SYM_W        (SYM_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .data_i      (data_i),
    .data_q      (data_q),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .pilot_sign  (pilot_sign),
    .pilot_valid (pilot_valid),
    .pilot_ready (pilot_ready),
    .ready_in    (ready_in),
    .real_out    (real_out),
    .imag_out    (imag_out),
    .valid_out   (valid_out),
    .sop_out     (sop_out),
    .eop_out     (eop_out),
    .sym_cnt     (sym_cnt)
  );

  always #5 clk = ~clk;

  // Hand-derived map for N=16, guard 2, step 4, offset 2: 0=null 1=pilot 2=data
  int tbl [16] = '{0, 2, 1, 2, 2, 2, 0, 0, 0, 0, 1, 2, 2, 2, 1, 2};

  int n_checks = 0;
  int n_fail   = 0;

  int          m_k;
  logic        m_valid, m_sop, m_eop;
  logic [15:0] m_real, m_imag, m_sym;
  int          d_idx, p_idx;
  int          n_dhs, n_phs, n_xfer, n_sop, n_eop, n_zero;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_valid = 1'b0; m_sop = 1'b0; m_eop = 1'b0;
    m_real = '0; m_imag = '0; m_sym = '0;
  endtask

  // One clock: check outputs, drive inputs, check readies, advance the model
  task automatic step(input logic e, input logic dv, input logic pv, input logic rdy);
    logic can;
    int   cls;
    logic dhs, phs;
    @(negedge clk);
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("sop_out",   32'(sop_out),   32'(m_sop));
    check("eop_out",   32'(eop_out),   32'(m_eop));
    check("real_out",  32'(real_out),  32'(m_real));
    check("imag_out",  32'(imag_out),  32'(m_imag));
    check("sym_cnt",   32'(sym_cnt),   32'(m_sym));
    if (!valid_out) n_zero++;
    en          = e;
    data_valid  = dv;
    pilot_valid = pv;
    ready_in    = rdy;
    data_i      = 16'(1000 + d_idx);
    data_q      = 16'(2000 + d_idx);
    pilot_sign  = ~p_idx[0];
    #1;
    can = e & (~m_valid | rdy);
    cls = tbl[m_k];
    check("data_ready",  32'(data_ready),  32'(can && cls == 2));
    check("pilot_ready", 32'(pilot_ready), 32'(can && cls == 1));
    dhs = data_ready & dv;
    phs = pilot_ready & pv;
    if (e && valid_out && rdy) begin
      n_xfer++;
      if (sop_out) n_sop++;
      if (eop_out) n_eop++;
    end
    if (can && (cls == 0 || (cls == 1 && pv) || (cls == 2 && dv))) begin
      m_valid = 1'b1;
      m_real  = (cls == 0) ? 16'h0000 : (cls == 1) ? (pilot_sign ? 16'hD2BF : 16'h2D41) : data_i;
      m_imag  = (cls == 2) ? data_q : 16'h0000;
      m_sop   = (m_k == 0);
      m_eop   = (m_k == 15);
      if (m_k == 15) m_sym = m_sym + 16'd1;
      m_k = (m_k + 1) % 16;
    end else if (can) begin
      m_valid = 1'b0;
      m_sop   = 1'b0;
      m_eop   = 1'b0;
    end
    if (dhs) begin d_idx++; n_dhs++; end
    if (phs) begin p_idx++; n_phs++; end
  endtask

  initial begin
    int g;
    int d0, p0;
    rst = 1'b0; en = 1'b0; data_valid = 1'b0; pilot_valid = 1'b0;
    pilot_sign = 1'b0; ready_in = 1'b0; data_i = '0; data_q = '0;
    d_idx = 0; p_idx = 0;
    n_dhs = 0; n_phs = 0; n_xfer = 0; n_sop = 0; n_eop = 0; n_zero = 0;
    model_reset();

    #2 rst = 1'b1;
    #2;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_sop",   32'(sop_out),   32'd0);
    check("rst_eop",   32'(eop_out),   32'd0);
    check("rst_real",  32'(real_out),  32'd0);
    check("rst_imag",  32'(imag_out),  32'd0);
    check("rst_sym",   32'(sym_cnt),   32'd0);
    check("n_data_pkg", 32'(n_data_per_sym(16, 2, 4, 2)), 32'd8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three symbols at full throughput with classification and pilot sign checks
    for (int s = 0; s < 49; s++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      if (s == 1) begin
        check("dc_sop",  32'(sop_out),  32'd1);
        check("dc_null", 32'(real_out), 32'd0);
      end
      if (s == 3) begin
        check("pilot_neg_re", 32'(real_out), 32'h0000_D2BF);
        check("pilot_neg_im", 32'(imag_out), 32'd0);
      end
      if (s == 11) begin
        check("pilot_pos_re", 32'(real_out), 32'h0000_2D41);
        check("pilot_pos_im", 32'(imag_out), 32'd0);
      end
      if (s == 16) begin
        check("eop_k15",    32'(eop_out), 32'd1);
        check("sym0_data",  32'(n_dhs),   32'd8);
        check("sym0_pilot", 32'(n_phs),   32'd3);
        check("sym0_xfer",  32'(n_xfer),  32'd16);
      end
    end
    check("sym3_cnt",   32'(sym_cnt), 32'd3);
    check("sym3_xfer",  32'(n_xfer),  32'd48);
    check("sym3_sop",   32'(n_sop),   32'd3);
    check("sym3_eop",   32'(n_eop),   32'd3);
    check("sym3_data",  32'(n_dhs),   32'd24);
    check("sym3_pilot", 32'(n_phs),   32'd9);

    // Data starvation at k=4
    n_zero = 0;
    g = 0;
    while (m_k != 4 && g < 40) begin step(1'b1, 1'b1, 1'b1, 1'b1); g++; end
    if (g >= 40) check("timeout_k4", 32'(g), 32'd0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("starve_valid", 32'(valid_out), 32'd1);
    check("starve_re",    32'(real_out),  32'd1026);
    check("starve_im",    32'(imag_out),  32'd2026);
    check("starve_gaps",  32'(n_zero),    32'd3);

    // Backpressure mid-symbol, then clock-enable low
    g = 0;
    while (m_k != 8 && g < 40) begin step(1'b1, 1'b1, 1'b1, 1'b1); g++; end
    if (g >= 40) check("timeout_k8", 32'(g), 32'd0);
    d0 = n_dhs;
    p0 = n_phs;
    repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("bp_no_data",  32'(n_dhs), 32'(d0));
    check("bp_no_pilot", 32'(n_phs), 32'(p0));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1);
    check("en_low_hold", 32'(valid_out), 32'd1);

    // Asynchronous reset with k=9 pending
    check("pre_rst_k9", 32'(m_k), 32'd9);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_real",  32'(real_out),  32'd0);
    check("arst_imag",  32'(imag_out),  32'd0);
    check("arst_sop",   32'(sop_out),   32'd0);
    check("arst_eop",   32'(eop_out),   32'd0);
    check("arst_sym",   32'(sym_cnt),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("post_rst_valid", 32'(valid_out), 32'd1);
    check("post_rst_sop",   32'(sop_out),   32'd1);
    check("post_rst_null",  32'(real_out),  32'd0);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
